// File: rtl/snitch_icache_refill_arb.sv
// Refill arbiter: merges per-port L0 refill requests onto one shared L1 request
// channel in round-robin order and routes L1 responses back to their port by ID.
module snitch_icache_refill_arb #(
  parameter int NR_FETCH_PORTS = 2,
  parameter int FETCH_AW       = 32,
  parameter int LINE_WIDTH     = 128,
  parameter int ID_WIDTH       = 4
) (
  input  logic                                    clk_i,
  input  logic                                    rst_i,

  input  logic [NR_FETCH_PORTS-1:0][FETCH_AW-1:0] in_req_addr_i,
  input  logic [NR_FETCH_PORTS-1:0]               in_req_valid_i,
  output logic [NR_FETCH_PORTS-1:0]               in_req_ready_o,

  output logic [FETCH_AW-1:0]                     out_req_addr_o,
  output logic [ID_WIDTH-1:0]                     out_req_id_o,
  output logic                                    out_req_valid_o,
  input  logic                                    out_req_ready_i,

  input  logic [LINE_WIDTH-1:0]                   out_rsp_data_i,
  input  logic                                    out_rsp_error_i,
  input  logic [ID_WIDTH-1:0]                     out_rsp_id_i,
  input  logic                                    out_rsp_valid_i,
  output logic                                    out_rsp_ready_o,

  output logic [LINE_WIDTH-1:0]                   in_rsp_data_o,
  output logic                                    in_rsp_error_o,
  output logic [NR_FETCH_PORTS-1:0]               in_rsp_valid_o,
  input  logic [NR_FETCH_PORTS-1:0]               in_rsp_ready_i,

  output logic [NR_FETCH_PORTS-1:0]               pending_o,
  output logic                                    stall_o,
  output logic                                    bad_id_o
);

  localparam int RR_W = (NR_FETCH_PORTS > 1) ? $clog2(NR_FETCH_PORTS) : 1;
  localparam logic [RR_W-1:0] LAST_PORT = RR_W'(NR_FETCH_PORTS - 1);

  logic [NR_FETCH_PORTS-1:0] pending_q;
  logic [RR_W-1:0]           rr_q;
  logic                      out_valid_q;
  logic [FETCH_AW-1:0]       out_addr_q;
  logic [ID_WIDTH-1:0]       out_id_q;

  logic [NR_FETCH_PORTS-1:0] eligible;
  logic [NR_FETCH_PORTS-1:0] grant;
  logic [NR_FETCH_PORTS-1:0] rsp_hit;
  logic [RR_W-1:0]           winner;
  logic                      any_eligible;
  logic                      slot_free;
  logic                      accept;
  logic                      rsp_match;
  logic                      rsp_fire;

  assign eligible     = in_req_valid_i & ~pending_q;
  assign any_eligible = |eligible;
  assign slot_free    = ~out_valid_q | out_req_ready_i;
  assign accept       = any_eligible & slot_free & ~rst_i;

  // Lowest eligible port overall is the wrap-around fallback; the lowest one
  // at or above rr_q overrides it when present.
  always_comb begin
    winner = '0;
    for (int p = NR_FETCH_PORTS - 1; p >= 0; p--) begin
      if (eligible[p]) winner = RR_W'(p);
    end
    for (int p = NR_FETCH_PORTS - 1; p >= 0; p--) begin
      if (eligible[p] && (RR_W'(p) >= rr_q)) winner = RR_W'(p);
    end
  end

  always_comb begin
    grant         = '0;
    grant[winner] = accept;
  end

  assign in_req_ready_o = grant;
  assign stall_o        = |(in_req_valid_i & ~grant);

  // Response routing: only an ID naming a port with an outstanding refill hits.
  always_comb begin
    rsp_hit = '0;
    for (int k = 0; k < NR_FETCH_PORTS; k++) begin
      rsp_hit[k] = pending_q[k] && (out_rsp_id_i == ID_WIDTH'(k));
    end
  end

  assign rsp_match       = |rsp_hit;
  assign in_rsp_valid_o  = {NR_FETCH_PORTS{out_rsp_valid_i}} & rsp_hit;
  assign in_rsp_data_o   = out_rsp_data_i;
  assign in_rsp_error_o  = out_rsp_error_i;
  // Orphans are always sunk so a stale L1 response can never block the channel.
  assign out_rsp_ready_o = ~rst_i & (rsp_match ? |(in_rsp_ready_i & rsp_hit) : 1'b1);
  assign rsp_fire        = out_rsp_valid_i & out_rsp_ready_o & rsp_match;
  assign bad_id_o        = out_rsp_valid_i & ~rsp_match;

  assign out_req_valid_o = out_valid_q;
  assign out_req_addr_o  = out_addr_q;
  assign out_req_id_o    = out_id_q;
  assign pending_o       = pending_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_id_q    <= '0;
      pending_q   <= '0;
      rr_q        <= '0;
    end else begin
      if (accept) begin
        out_valid_q <= 1'b1;
        out_addr_q  <= in_req_addr_i[winner];
        out_id_q    <= ID_WIDTH'(winner);
        rr_q        <= (winner == LAST_PORT) ? '0 : winner + RR_W'(1);
      end else if (out_req_ready_i) begin
        out_valid_q <= 1'b0;
      end
      // Accept needs !pending and a hit needs pending, so set and clear never collide.
      pending_q <= (pending_q & ~(rsp_fire ? rsp_hit : '0)) | grant;
    end
  end

endmodule

// File: tb/tb_snitch_icache_refill_arb.sv
// Bench for the refill arbiter: directed scenarios followed by random traffic,
// all checked against a queue-based reference model and two scoreboards.
module tb_snitch_icache_refill_arb;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int LW = 128;
  localparam int IW = 4;

  logic                 clk = 1'b0;
  logic                 rst_i;
  logic [N-1:0][AW-1:0] in_req_addr_i;
  logic [N-1:0]         in_req_valid_i;
  logic [N-1:0]         in_req_ready_o;
  logic [AW-1:0]        out_req_addr_o;
  logic [IW-1:0]        out_req_id_o;
  logic                 out_req_valid_o;
  logic                 out_req_ready_i;
  logic [LW-1:0]        out_rsp_data_i;
  logic                 out_rsp_error_i;
  logic [IW-1:0]        out_rsp_id_i;
  logic                 out_rsp_valid_i;
  logic                 out_rsp_ready_o;
  logic [LW-1:0]        in_rsp_data_o;
  logic                 in_rsp_error_o;
  logic [N-1:0]         in_rsp_valid_o;
  logic [N-1:0]         in_rsp_ready_i;
  logic [N-1:0]         pending_o;
  logic                 stall_o;
  logic                 bad_id_o;

  always #5 clk = ~clk;

  snitch_icache_refill_arb #(
    .NR_FETCH_PORTS(N), .FETCH_AW(AW), .LINE_WIDTH(LW), .ID_WIDTH(IW)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .in_req_addr_i(in_req_addr_i), .in_req_valid_i(in_req_valid_i), .in_req_ready_o(in_req_ready_o),
    .out_req_addr_o(out_req_addr_o), .out_req_id_o(out_req_id_o),
    .out_req_valid_o(out_req_valid_o), .out_req_ready_i(out_req_ready_i),
    .out_rsp_data_i(out_rsp_data_i), .out_rsp_error_i(out_rsp_error_i), .out_rsp_id_i(out_rsp_id_i),
    .out_rsp_valid_i(out_rsp_valid_i), .out_rsp_ready_o(out_rsp_ready_o),
    .in_rsp_data_o(in_rsp_data_o), .in_rsp_error_o(in_rsp_error_o),
    .in_rsp_valid_o(in_rsp_valid_o), .in_rsp_ready_i(in_rsp_ready_i),
    .pending_o(pending_o), .stall_o(stall_o), .bad_id_o(bad_id_o)
  );

  typedef struct { logic [AW-1:0] addr; int id; } req_t;
  typedef struct { int port; logic [LW-1:0] data; logic err; } rsp_t;

  req_t exp_req_q[$];
  rsp_t exp_rsp_q[$];
  int   l1_q[$];

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit            m_pend[N];
  int            m_rr;
  bit            m_slot_v;
  int            m_slot_id;
  int            acc_port;
  bit            rsp_fired;
  bit            rsp_active;

  function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endfunction

  function automatic logic [N-1:0] pend_vec();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_pend[i];
    return v;
  endfunction

  // One clock cycle: compare at the falling edge, advance the model, return just after the rising edge.
  task automatic tick();
    int w, k;
    bit any, accept, hit, ordy;
    logic [N-1:0] e_rdy, e_rv;
    rsp_t rs;
    req_t rq;
    @(negedge clk);
    any = 0;
    w = 0;
    if (!rst_i) begin
      for (int j = 0; j < N; j++) begin
        int p;
        p = (m_rr + j) % N;
        if (!any && in_req_valid_i[p] && !m_pend[p]) begin
          any = 1;
          w = p;
        end
      end
    end
    accept = any && (!m_slot_v || out_req_ready_i);
    e_rdy = '0;
    if (accept) e_rdy[w] = 1'b1;
    k = int'(out_rsp_id_i);
    hit = (k < N) ? m_pend[k] : 1'b0;
    ordy = rst_i ? 1'b0 : (hit ? in_rsp_ready_i[k] : 1'b1);
    e_rv = '0;
    if (hit && out_rsp_valid_i) e_rv[k] = 1'b1;

    chk("in_req_ready", 128'(in_req_ready_o), 128'(e_rdy));
    chk("stall", 128'(stall_o), 128'(|(in_req_valid_i & ~e_rdy)));
    chk("in_rsp_valid", 128'(in_rsp_valid_o), 128'(e_rv));
    chk("out_rsp_ready", 128'(out_rsp_ready_o), 128'(ordy));
    chk("bad_id", 128'(bad_id_o), 128'(out_rsp_valid_i && !hit));
    chk("pending", 128'(pending_o), 128'(pend_vec()));
    chk("out_req_valid", 128'(out_req_valid_o), 128'(m_slot_v));

    if (hit && out_rsp_valid_i && ordy) begin
      rs.port = k;
      rs.data = out_rsp_data_i;
      rs.err  = out_rsp_error_i;
      exp_rsp_q.push_back(rs);
    end
    acc_port  = accept ? w : -1;
    rsp_fired = out_rsp_valid_i && ordy;

    if (rst_i) begin
      for (int i = 0; i < N; i++) m_pend[i] = 0;
      m_rr = 0;
      m_slot_v = 0;
      exp_req_q.delete();
      l1_q.delete();
    end else begin
      if (hit && out_rsp_valid_i && ordy) m_pend[k] = 0;
      if (m_slot_v && out_req_ready_i) l1_q.push_back(m_slot_id);
      if (accept) begin
        m_slot_v  = 1;
        m_slot_id = w;
        m_pend[w] = 1;
        m_rr      = (w + 1) % N;
        rq.addr   = in_req_addr_i[w];
        rq.id     = w;
        exp_req_q.push_back(rq);
      end else if (out_req_ready_i) begin
        m_slot_v = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: pops expectations whenever the DUT completes a handshake.
  initial begin
    req_t er;
    rsp_t es;
    logic [N-1:0] hs, want;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_i) begin
        if (out_req_valid_o && out_req_ready_i) begin
          if (exp_req_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL req_sb actual=unexpected_request required=none t=%0t", $time);
          end else begin
            er = exp_req_q.pop_front();
            chk("req_addr", 128'(out_req_addr_o), 128'(er.addr));
            chk("req_id", 128'(out_req_id_o), 128'(er.id));
          end
        end
        hs = in_rsp_valid_o & in_rsp_ready_i;
        if (|hs) begin
          if (exp_rsp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rsp_sb actual=unexpected_response required=none t=%0t", $time);
          end else begin
            es = exp_rsp_q.pop_front();
            want = '0;
            want[es.port] = 1'b1;
            chk("rsp_port", 128'(hs), 128'(want));
            chk("rsp_data", in_rsp_data_o, es.data);
            chk("rsp_err", 128'(in_rsp_error_o), 128'(es.err));
          end
        end
      end
    end
  end

  task automatic idle_inputs();
    in_req_valid_i  = '0;
    out_req_ready_i = 1'b0;
    out_rsp_valid_i = 1'b0;
    out_rsp_id_i    = '0;
    out_rsp_data_i  = '0;
    out_rsp_error_i = 1'b0;
    in_rsp_ready_i  = '0;
  endtask

  task automatic rand_cycle();
    int r;
    int cand[$];
    for (int i = 0; i < N; i++) begin
      if (acc_port == i) in_req_valid_i[i] = 1'b0;
      if (!in_req_valid_i[i] && $urandom_range(0, 2) == 0) begin
        in_req_valid_i[i] = 1'b1;
        in_req_addr_i[i]  = $urandom;
      end
    end
    rst_i           = ($urandom_range(0, 499) == 0);
    out_req_ready_i = ($urandom_range(0, 3) != 0);
    in_rsp_ready_i  = N'($urandom);
    if (rsp_fired) rsp_active = 0;
    if (!rsp_active) begin
      r = $urandom_range(0, 9);
      if (r < 5 && l1_q.size() > 0) begin
        rsp_active   = 1;
        out_rsp_id_i = IW'(l1_q.pop_front());
      end else if (r == 5) begin
        rsp_active = 1;
        for (int i = 0; i < N; i++) if (!m_pend[i]) cand.push_back(i);
        if (cand.size() > 0 && $urandom_range(0, 1) == 1)
          out_rsp_id_i = IW'(cand[$urandom_range(0, cand.size() - 1)]);
        else
          out_rsp_id_i = IW'($urandom_range(N, (1 << IW) - 1));
      end
      if (rsp_active) begin
        out_rsp_data_i  = {$urandom, $urandom, $urandom, $urandom};
        out_rsp_error_i = ($urandom_range(0, 3) == 0);
      end
    end
    out_rsp_valid_i = rsp_active;
    tick();
  endtask

  initial begin
    rst_i = 1'b1;
    idle_inputs();
    in_req_addr_i = '0;
    for (int i = 0; i < N; i++) m_pend[i] = 0;
    m_rr = 0;
    m_slot_v = 0;
    m_slot_id = 0;
    acc_port = -1;
    rsp_fired = 0;
    rsp_active = 0;
    @(posedge clk);
    #1;
    tick();
    tick();

    // Reset release state
    rst_i = 1'b0;
    #1;
    chk("rst_out_valid", 128'(out_req_valid_o), 128'(0));
    chk("rst_pending", 128'(pending_o), 128'(0));
    chk("rst_in_rsp_valid", 128'(in_rsp_valid_o), 128'(0));

    // Two simultaneous requesters, L1 always ready
    in_req_valid_i = 2'b11;
    in_req_addr_i[0] = 32'h100;
    in_req_addr_i[1] = 32'h200;
    out_req_ready_i = 1'b1;
    #1;
    chk("c0_grant", 128'(in_req_ready_o), 128'(2'b01));
    chk("c0_stall", 128'(stall_o), 128'(1));
    tick();
    in_req_valid_i = 2'b10;
    #1;
    chk("c1_valid", 128'(out_req_valid_o), 128'(1));
    chk("c1_addr", 128'(out_req_addr_o), 128'(32'h100));
    chk("c1_id", 128'(out_req_id_o), 128'(0));
    chk("c1_grant", 128'(in_req_ready_o), 128'(2'b10));
    tick();
    in_req_valid_i = 2'b00;
    #1;
    chk("c2_addr", 128'(out_req_addr_o), 128'(32'h200));
    chk("c2_id", 128'(out_req_id_o), 128'(1));
    tick();
    out_req_ready_i = 1'b0;
    #1;
    chk("both_pending", 128'(pending_o), 128'(2'b11));

    // Response to port 1 held off by its requester for two cycles
    out_rsp_valid_i = 1'b1;
    out_rsp_id_i    = 4'd1;
    out_rsp_data_i  = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
    out_rsp_error_i = 1'b0;
    in_rsp_ready_i  = 2'b00;
    for (int c = 0; c < 2; c++) begin
      #1;
      chk("rsp1_hold_valid", 128'(in_rsp_valid_o), 128'(2'b10));
      chk("rsp1_hold_ready", 128'(out_rsp_ready_o), 128'(0));
      tick();
    end
    in_rsp_ready_i = 2'b10;
    #1;
    chk("rsp1_ready", 128'(out_rsp_ready_o), 128'(1));
    tick();
    out_rsp_valid_i = 1'b0;
    in_rsp_ready_i  = 2'b00;
    #1;
    chk("rsp1_cleared", 128'(pending_o), 128'(2'b01));

    // Port 0 re-requests while pending; an error response frees it
    in_req_valid_i   = 2'b01;
    in_req_addr_i[0] = 32'h300;
    #1;
    chk("repend_blocked", 128'(in_req_ready_o), 128'(0));
    chk("repend_stall", 128'(stall_o), 128'(1));
    tick();
    out_rsp_valid_i = 1'b1;
    out_rsp_id_i    = 4'd0;
    out_rsp_data_i  = 128'hcafe;
    out_rsp_error_i = 1'b1;
    in_rsp_ready_i  = 2'b01;
    #1;
    chk("same_cycle_block", 128'(in_req_ready_o), 128'(0));
    chk("err_rsp_ready", 128'(out_rsp_ready_o), 128'(1));
    tick();
    out_rsp_valid_i = 1'b0;
    out_rsp_error_i = 1'b0;
    in_rsp_ready_i  = 2'b00;
    out_req_ready_i = 1'b1;
    #1;
    chk("reaccept", 128'(in_req_ready_o), 128'(2'b01));
    tick();

    // L1 back-pressure: payload stable, waiting requester stalls
    in_req_valid_i   = 2'b10;
    in_req_addr_i[1] = 32'h400;
    out_req_ready_i  = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("bp_valid", 128'(out_req_valid_o), 128'(1));
      chk("bp_addr", 128'(out_req_addr_o), 128'(32'h300));
      chk("bp_id", 128'(out_req_id_o), 128'(0));
      chk("bp_no_grant", 128'(in_req_ready_o), 128'(0));
      chk("bp_stall", 128'(stall_o), 128'(1));
      tick();
    end
    out_req_ready_i = 1'b1;
    #1;
    chk("b2b_grant", 128'(in_req_ready_o), 128'(2'b10));
    tick();
    in_req_valid_i = 2'b00;
    #1;
    chk("b2b_addr", 128'(out_req_addr_o), 128'(32'h400));
    chk("b2b_id", 128'(out_req_id_o), 128'(1));
    tick();

    // Orphans: out-of-range ID, then a port with nothing outstanding
    out_rsp_valid_i = 1'b1;
    out_rsp_id_i    = 4'd3;
    in_rsp_ready_i  = 2'b00;
    #1;
    chk("orph3_ready", 128'(out_rsp_ready_o), 128'(1));
    chk("orph3_bad", 128'(bad_id_o), 128'(1));
    chk("orph3_valid", 128'(in_rsp_valid_o), 128'(0));
    tick();
    out_rsp_id_i   = 4'd0;
    in_rsp_ready_i = 2'b01;
    #1;
    chk("good0_bad", 128'(bad_id_o), 128'(0));
    tick();
    in_rsp_ready_i = 2'b00;
    #1;
    chk("orph0_ready", 128'(out_rsp_ready_o), 128'(1));
    chk("orph0_bad", 128'(bad_id_o), 128'(1));
    chk("orph0_valid", 128'(in_rsp_valid_o), 128'(0));
    tick();
    out_rsp_valid_i = 1'b0;
    #1;
    chk("orph_state", 128'(pending_o), 128'(2'b10));

    // Reset with a request in flight and both ports pending
    in_req_valid_i   = 2'b01;
    in_req_addr_i[0] = 32'h500;
    out_req_ready_i  = 1'b0;
    tick();
    in_req_valid_i  = 2'b00;
    rst_i           = 1'b1;
    out_rsp_valid_i = 1'b1;
    out_rsp_id_i    = 4'd3;
    #1;
    chk("pre_rst_pending", 128'(pending_o), 128'(2'b11));
    chk("pre_rst_valid", 128'(out_req_valid_o), 128'(1));
    chk("rst_rsp_ready", 128'(out_rsp_ready_o), 128'(0));
    tick();
    rst_i            = 1'b0;
    out_rsp_valid_i  = 1'b0;
    in_req_valid_i   = 2'b11;
    in_req_addr_i[0] = 32'h600;
    in_req_addr_i[1] = 32'h700;
    out_req_ready_i  = 1'b1;
    #1;
    chk("post_rst_valid", 128'(out_req_valid_o), 128'(0));
    chk("post_rst_pending", 128'(pending_o), 128'(0));
    chk("post_rst_grant", 128'(in_req_ready_o), 128'(2'b01));
    tick();
    in_req_valid_i = 2'b10;
    #1;
    chk("post_rst_addr", 128'(out_req_addr_o), 128'(32'h600));
    tick();

    // Random traffic
    in_req_valid_i = 2'b00;
    out_rsp_valid_i = 1'b0;
    rsp_active = 0;
    rsp_fired = 0;
    for (int c = 0; c < 4000; c++) rand_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/snitch_icache_refill_arb.md
SNITCH_ICACHE_REFILL_ARB -- requirements
Module: snitch_icache_refill_arb

Interface
REQ-001 SHALL have parameter NR_FETCH_PORTS, default 2, number of L0 requesters (1..16).
REQ-002 SHALL have parameter FETCH_AW, default 32, refill address width.
REQ-003 SHALL have parameter LINE_WIDTH, default 128, refill line data width.
REQ-004 SHALL have parameter ID_WIDTH, default 4, refill ID width, >= max(1, clog2(NR_FETCH_PORTS)).
REQ-005 SHALL have port clk_i  in  1  single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_i  in  1  reset, synchronous, active-high.
REQ-007 SHALL have ports in_req_addr_i  in  NR_FETCH_PORTS x FETCH_AW, in_req_valid_i  in  NR_FETCH_PORTS, in_req_ready_o  out  NR_FETCH_PORTS  per-port refill requests.
REQ-008 SHALL have ports out_req_addr_o  out  FETCH_AW, out_req_id_o  out  ID_WIDTH, out_req_valid_o  out  1, out_req_ready_i  in  1  shared L1 request.
REQ-009 SHALL have ports out_rsp_data_i  in  LINE_WIDTH, out_rsp_error_i  in  1, out_rsp_id_i  in  ID_WIDTH, out_rsp_valid_i  in  1, out_rsp_ready_o  out  1  L1 response.
REQ-010 SHALL have ports in_rsp_data_o  out  LINE_WIDTH, in_rsp_error_o  out  1 (shared), in_rsp_valid_o  out  NR_FETCH_PORTS, in_rsp_ready_i  in  NR_FETCH_PORTS  per-port responses.
REQ-011 SHALL have ports pending_o  out  NR_FETCH_PORTS (outstanding mask), stall_o  out  1 (arbitration stall event), bad_id_o  out  1 (orphan response event).

Function
REQ-012 SHALL hold pending_q[i]=1 while port i has an accepted, unanswered refill; at most one outstanding per port.
REQ-013 Port i eligible iff in_req_valid_i[i] & !pending_q[i].
REQ-014 Round-robin: winner = first eligible port searching from rr_q upward, wrapping at NR_FETCH_PORTS-1 -> 0.
REQ-015 Output slot free iff !out_valid_q | out_req_ready_i.
REQ-016 in_req_ready_o[i] = (i == winner) & any-eligible & slot free; at most one bit set per cycle.
REQ-017 On accept of port i: out_valid_q<=1, out_addr_q<=in_req_addr_i[i], out_id_q<=i zero-extended, pending_q[i]<=1, rr_q<=(i+1) mod NR_FETCH_PORTS.
REQ-018 out_req_valid_o/addr_o/id_o SHALL be driven from registers; request latency exactly 1 cycle accept-to-valid.
REQ-019 While out_req_valid_o & !out_req_ready_i, addr/id/valid SHALL stay stable.
REQ-020 L1 handshake without new accept same cycle: out_valid_q<=0; with new accept: back-to-back, out_valid_q stays 1 with new payload.
REQ-021 rr_q unchanged in cycles without accept.
REQ-022 Response routing combinational: k = out_rsp_id_i; if k < NR_FETCH_PORTS and pending_q[k]: in_rsp_valid_o[k]=out_rsp_valid_i, others 0, out_rsp_ready_o=in_rsp_ready_i[k].
REQ-023 in_rsp_data_o = out_rsp_data_i, in_rsp_error_o = out_rsp_error_i, unconditionally.
REQ-024 On response handshake for valid k: pending_q[k]<=0; port k eligible again from next cycle (no same-cycle re-accept).
REQ-025 Orphan response (k >= NR_FETCH_PORTS or !pending_q[k]) with out_rsp_valid_i: out_rsp_ready_o=1, no in_rsp_valid_o asserted, data dropped, bad_id_o=1 that cycle; state unchanged.
REQ-026 Error responses SHALL clear pending identically to normal ones.
REQ-027 stall_o=1 in any cycle where some in_req_valid_i[i] & !in_req_ready_o[i], else 0.
REQ-028 pending_o = pending_q.
REQ-029 NR_FETCH_PORTS=1: rr_q fixed 0, behaviour otherwise identical.

Reset
REQ-030 While rst_i=1 at a clock edge: out_valid_q=0, pending_q=0, rr_q=0, out_addr_q=0, out_id_q=0.
REQ-031 During reset cycles in_req_ready_o=0 and out_rsp_ready_o=0; outstanding transactions are discarded; responses arriving later are treated as orphans.
REQ-032 After reset release: out_req_valid_o=0, in_rsp_valid_o=0, pending_o=0, stall_o/bad_id_o follow inputs combinationally.

Verification
REQ-033 N=2, both valid (A=0x100,B=0x200) cycle 0, out_req_ready_i=1 -> port0 accepted c0, out 0x100/id0 at c1; port1 accepted c1, out 0x200/id1 at c2; stall_o=1 at c0.
REQ-034 out_req_ready_i=0 for 3 cycles after first accept -> addr/id/valid stable 3 cycles, in_req_ready_o all 0, stall_o=1 for waiting requesters.
REQ-035 Port0 pending, port0 requests again -> no accept until response id0 handshakes; accept earliest the following cycle.
REQ-036 Response id=1, in_rsp_ready_i[1]=0 for 2 cycles then 1 -> in_rsp_valid_o=0b10 held, out_rsp_ready_o=0 then 1, pending_o[1] clears next cycle.
REQ-037 Response id=3 with N=2, or id=0 with pending_o[0]=0 -> out_rsp_ready_o=1, bad_id_o=1, no in_rsp_valid_o, state unchanged.
REQ-038 rst_i asserted with out_valid_q=1 and pending_o=0b11 -> next cycle out_req_valid_o=0, pending_o=0, rr_q=0; first post-reset grant goes to port0.
